hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencing controller for the 5-stage MIPS core. Drives active-low
//  enables and flush (synchronous clear) inputs of the PC, IF/ID and ID/EX
//  pipeline registers. Resolves load-use stalls, branch-taken flushes and the
//  multi-cycle mult/div busy window. Sits beside the ID stage; outputs feed the
//  en_n/rst pins of the stage registers.
// PARAMETERS
//  REG_ADDR_W     5   register-file address width
//  MULDIV_CYCLES  32  mult/div execution latency in cycles; must be >= 2
//  CNT_W          16  perf counter width (HAZ_PERF_CNT_EN only)
// PORTS
//  clk          in   1           rising-edge clock
//  rst          in   1           asynchronous, active-high reset
//  id_rs        in   REG_ADDR_W  rs field of instruction in ID
//  id_rt        in   REG_ADDR_W  rt field of instruction in ID
//  id_uses_rt   in   1           ID instruction reads rt as a source
//  id_md_use    in   1           ID instruction reads HI/LO or is mult/div
//  id_md_start  in   1           ID instruction is mult/div (starts unit on advance)
//  ex_mem_read  in   1           EX instruction is a load
//  ex_rt        in   REG_ADDR_W  destination of EX load
//  br_taken     in   1           branch/jump in EX resolved taken
//  pc_en_n      out  1           PC hold (1 = hold)
//  ifid_en_n    out  1           IF/ID hold (1 = hold)
//  ifid_flush   out  1           IF/ID clear
//  idex_flush   out  1           ID/EX clear (insert bubble)
//  ctrl_state   out  2           registered FSM state
//  stall_cnt    out  CNT_W       stall cycles (HAZ_PERF_CNT_EN only)
//  flush_cnt    out  CNT_W       flush events (HAZ_PERF_CNT_EN only)
// BEHAVIOUR
//  - States: RUN=2'd0, LDUSE=2'd1, MDBUSY=2'd2; 2'd3 unused -> RUN.
//  - Reset (async): state=RUN, md_cnt=0, perf counters=0. While rst=1 outputs
//    forced pc_en_n=1, ifid_en_n=1, ifid_flush=1, idex_flush=1.
//  - load_use = ex_mem_read & (ex_rt!=0) &
//    ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
//  - md_busy = (state==MDBUSY) & (md_cnt!=0); md_stall = md_busy & id_md_use.
//  - Outputs combinational (Mealy), same cycle, priority order:
//    1 br_taken: ifid_flush=1, idex_flush=1, pc_en_n=0, ifid_en_n=0.
//    2 load_use | md_stall: pc_en_n=1, ifid_en_n=1, idex_flush=1, ifid_flush=0.
//    3 else all four outputs 0 (advance).
//  - advance = !br_taken & !load_use & !md_stall.
//  - Transitions: RUN->LDUSE when load_use & !br_taken; LDUSE->RUN always
//    (one bubble only, forwarding covers MEM->EX). Entry to MDBUSY when
//    advance & id_md_start (from any state), md_cnt<=MULDIV_CYCLES-1.
//    MDBUSY: md_cnt decrements while !=0; at md_cnt==0 -> RUN unless reload.
//  - md_cnt==0 with advance & id_md_start same cycle: reload, stay MDBUSY.
//  - id_md_start during stall or br_taken: ignored (instr not issued).
//  - br_taken during MDBUSY: flush, md_cnt keeps counting (unit already busy).
//  - load_use in MDBUSY: stall, stay MDBUSY (counter continues).
//  - Max md stall = MULDIV_CYCLES-1 cycles after issue.
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined: stall_cnt += 1 each cycle pc_en_n=1 & !rst;
//  flush_cnt += 1 each cycle br_taken=1; both saturate at all-ones.
//  Undefined: counters and both ports absent; no other change.
// STRUCTURE
//  - haz_defs.vh (shared include): state localparams HAZ_RUN/HAZ_LDUSE/
//    HAZ_MDBUSY, state width 2; included by hazard_ctrl and benches.
//  - Sub-module muldiv_timer: loadable down-counter (load, value, busy), width
//    $clog2(MULDIV_CYCLES), async active-high rst.
// TESTING
//  1 rst mid-MDBUSY (md_cnt=10) -> outputs all 1 during rst; RUN, md_cnt=0 after.
//  2 ex_mem_read=1, ex_rt=8, id_rs=8 -> 1 cycle pc_en_n=ifid_en_n=idex_flush=1,
//    LDUSE then RUN; same with ex_rt=0 -> no stall.
//  3 MULDIV_CYCLES=4: issue mult, next instr id_md_use=1 -> stalled exactly 3
//    cycles, then advances; state back to RUN.
//  4 br_taken=1 together with load_use=1 -> ifid_flush=idex_flush=1,
//    pc_en_n=0, state stays RUN.
//  5 back-to-back mult at md_cnt==0 -> reload to 3, stays MDBUSY.
//  6 HAZ_PERF_CNT_EN, CNT_W=4: 20 stall cycles -> stall_cnt=4'hF saturated.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared types and constants for the pipeline hazard controller.
//   state_t  - registered sequencing state (RUN / LDUSE / MDBUSY, 2'd3 unused)
//   ctrl_t   - bundle of the four stage-register control outputs
//   CTRL_*   - the output patterns the controller can drive
// Optional feature macro used by the top: HAZ_PERF_CNT_EN.
package hazard_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    HAZ_RUN    = 2'd0,
    HAZ_LDUSE  = 2'd1,
    HAZ_MDBUSY = 2'd2
  } state_t;

  // Order matches the bundle {pc_en_n, ifid_en_n, ifid_flush, idex_flush}.
  typedef struct packed {
    logic pc_en_n;
    logic ifid_en_n;
    logic ifid_flush;
    logic idex_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_ADVANCE = 4'b0000;
  localparam ctrl_t CTRL_FLUSH   = 4'b0011;  // branch taken: kill IF/ID and ID/EX, keep fetching
  localparam ctrl_t CTRL_STALL   = 4'b1101;  // hold PC and IF/ID, bubble into ID/EX
  localparam ctrl_t CTRL_RESET   = 4'b1111;  // everything held and cleared while in reset

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side view of the hazard controller.
//   Pipeline -> controller : id_rs, id_rt, id_uses_rt, id_md_use, id_md_start,
//                            ex_mem_read, ex_rt, br_taken
//   Controller -> pipeline : pc_en_n, ifid_en_n, ifid_flush, idex_flush, ctrl_state
// modport master: the pipeline (drives decode/execute status, receives controls)
// modport slave : the controller
interface hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rt;
  logic                  id_md_use;
  logic                  id_md_start;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_rt;
  logic                  br_taken;

  logic                  pc_en_n;
  logic                  ifid_en_n;
  logic                  ifid_flush;
  logic                  idex_flush;
  logic [1:0]            ctrl_state;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_md_use, id_md_start,
           ex_mem_read, ex_rt, br_taken,
    input  pc_en_n, ifid_en_n, ifid_flush, idex_flush, ctrl_state
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_md_use, id_md_start,
           ex_mem_read, ex_rt, br_taken,
    output pc_en_n, ifid_en_n, ifid_flush, idex_flush, ctrl_state
  );
endinterface

// File: rtl/hazard_ctrl_muldiv_timer.sv
// muldiv_timer: loadable down-counter tracking the mult/div busy window.
//   clk, rst : clock, asynchronous active-high reset (count -> 0)
//   load     : load 'value' this cycle (takes priority over counting)
//   value    : reload value
//   busy     : count is non-zero
// The counter decrements every cycle while non-zero and rests at zero.
module muldiv_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         busy
);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: sequencing controller for the 5-stage MIPS pipeline.
// Resolves load-use stalls, branch-taken flushes and the mult/div busy window
// by driving the hold/clear pins of the PC, IF/ID and ID/EX registers.
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : hazard_ctrl_if.slave (ID/EX status in, stage controls out)
//   stall_cnt  : cycles with the PC held (only with HAZ_PERF_CNT_EN)
//   flush_cnt  : cycles with a taken branch (only with HAZ_PERF_CNT_EN)
// Optional feature: define HAZ_PERF_CNT_EN to add the saturating counters.
// Outputs are Mealy: they react to the ID/EX fields in the same cycle.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W    = 5,
  parameter int MULDIV_CYCLES = 32,  // must be >= 2
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  hazard_ctrl_if.slave     bus
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int MD_W = $clog2(MULDIV_CYCLES);

  logic [REG_ADDR_W-1:0] id_rs, id_rt, ex_rt;
  state_t state, state_nxt;
  ctrl_t  ctrl;
  logic   load_use, md_busy, md_stall, advance, md_issue, timer_busy;

  assign id_rs = bus.id_rs;
  assign id_rt = bus.id_rt;
  assign ex_rt = bus.ex_rt;

  // r0 is hard-wired, so a load targeting it never creates a dependency.
  assign load_use = bus.ex_mem_read && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (bus.id_uses_rt && (ex_rt == id_rt)));

  assign md_busy  = (state == HAZ_MDBUSY) && timer_busy;
  assign md_stall = md_busy && bus.id_md_use;
  assign advance  = !bus.br_taken && !load_use && !md_stall;
  // A mult/div only starts the unit if it actually leaves ID this cycle.
  assign md_issue = advance && bus.id_md_start;

  muldiv_timer #(.W(MD_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (md_issue),
    .value (MD_W'(MULDIV_CYCLES - 1)),
    .busy  (timer_busy)
  );

  // Output decode; branch flush outranks any stall because the stalled
  // instruction is on the wrong path anyway.
  // NOTE: every always_comb output gets a default first so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    ctrl = CTRL_ADVANCE;
    if (rst)                       ctrl = CTRL_RESET;
    else if (bus.br_taken)         ctrl = CTRL_FLUSH;
    else if (load_use || md_stall) ctrl = CTRL_STALL;
  end

  always_comb begin
    state_nxt = state;
    if (md_issue) begin
      // Covers a fresh issue from RUN/LDUSE and a back-to-back reload at md_cnt==0.
      state_nxt = HAZ_MDBUSY;
    end else begin
      case (state)
        HAZ_RUN:    if (load_use && !bus.br_taken) state_nxt = HAZ_LDUSE;
        // One bubble is enough: forwarding covers MEM->EX after that.
        HAZ_LDUSE:  state_nxt = HAZ_RUN;
        HAZ_MDBUSY: if (!timer_busy) state_nxt = HAZ_RUN;
        default:    state_nxt = HAZ_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HAZ_RUN;
    else     state <= state_nxt;
  end

  assign bus.pc_en_n    = ctrl.pc_en_n;
  assign bus.ifid_en_n  = ctrl.ifid_en_n;
  assign bus.ifid_flush = ctrl.ifid_flush;
  assign bus.idex_flush = ctrl.idex_flush;
  assign bus.ctrl_state = state;

`ifdef HAZ_PERF_CNT_EN
  // Saturating event counters; they stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (ctrl.pc_en_n && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (bus.br_taken && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl with
// MULDIV_CYCLES=4 and CNT_W=4. Define HAZ_PERF_CNT_EN to include the
// performance-counter scenario.
// Output vector order: {pc_en_n, ifid_en_n, ifid_flush, idex_flush}.
module tb_hazard_ctrl;

  localparam logic [3:0] O_ADV   = 4'b0000;
  localparam logic [3:0] O_FLUSH = 4'b0011;
  localparam logic [3:0] O_STALL = 4'b1101;
  localparam logic [3:0] O_RST   = 4'b1111;
  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_LDUSE = 2'd1;
  localparam logic [1:0] S_MDB   = 2'd2;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [3:0] outs;

  hazard_ctrl_if #(.REG_ADDR_W(5)) bus ();

`ifdef HAZ_PERF_CNT_EN
  logic [3:0] stall_cnt;
  logic [3:0] flush_cnt;
`endif

  hazard_ctrl #(
    .REG_ADDR_W    (5),
    .MULDIV_CYCLES (4),
    .CNT_W         (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  assign outs = {bus.pc_en_n, bus.ifid_en_n, bus.ifid_flush, bus.idex_flush};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.id_rs       = '0;
    bus.id_rt       = '0;
    bus.id_uses_rt  = 1'b0;
    bus.id_md_use   = 1'b0;
    bus.id_md_start = 1'b0;
    bus.ex_mem_read = 1'b0;
    bus.ex_rt       = '0;
    bus.br_taken    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    tick();
    tick();
    n_checks++;
    if (outs !== O_RST) begin
      n_fail++; $display("FAIL reset_outs: got %b want %b", outs, O_RST);
    end
    n_checks++;
    if (bus.ctrl_state !== S_RUN) begin
      n_fail++; $display("FAIL reset_state: got %0d want %0d", bus.ctrl_state, S_RUN);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (outs !== O_ADV) begin
      n_fail++; $display("FAIL post_reset_outs: got %b want %b", outs, O_ADV);
    end
    tick();
    n_checks++;
    if (bus.ctrl_state !== S_RUN) begin
      n_fail++; $display("FAIL post_reset_state: got %0d want %0d", bus.ctrl_state, S_RUN);
    end
  endtask

  task automatic test_load_use();
    // rs dependency on a load into r8
    set_idle();
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd8; bus.id_rs = 5'd8;
    #1;
    n_checks++;
    if (outs !== O_STALL) begin
      n_fail++; $display("FAIL ldu_rs_outs: got %b want %b", outs, O_STALL);
    end
    tick();
    n_checks++;
    if (bus.ctrl_state !== S_LDUSE) begin
      n_fail++; $display("FAIL ldu_rs_state: got %0d want %0d", bus.ctrl_state, S_LDUSE);
    end
    set_idle();  // bubble now in EX
    bus.id_rs = 5'd8;
    #1;
    n_checks++;
    if (outs !== O_ADV) begin
      n_fail++; $display("FAIL ldu_bubble_outs: got %b want %b", outs, O_ADV);
    end
    tick();
    n_checks++;
    if (bus.ctrl_state !== S_RUN) begin
      n_fail++; $display("FAIL ldu_back_run: got %0d want %0d", bus.ctrl_state, S_RUN);
    end
    // load into r0 never stalls
    set_idle();
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd0; bus.id_rs = 5'd0;
    #1;
    n_checks++;
    if (outs !== O_ADV) begin
      n_fail++; $display("FAIL ldu_r0_outs: got %b want %b", outs, O_ADV);
    end
    tick();
    n_checks++;
    if (bus.ctrl_state !== S_RUN) begin
      n_fail++; $display("FAIL ldu_r0_state: got %0d want %0d", bus.ctrl_state, S_RUN);
    end
    // rt match only counts when rt is a source
    set_idle();
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd5; bus.id_rt = 5'd5; bus.id_rs = 5'd3;
    #1;
    n_checks++;
    if (outs !== O_ADV) begin
      n_fail++; $display("FAIL ldu_rt_unused_outs: got %b want %b", outs, O_ADV);
    end
    bus.id_uses_rt = 1'b1;
    #1;
    n_checks++;
    if (outs !== O_STALL) begin
      n_fail++; $display("FAIL ldu_rt_used_outs: got %b want %b", outs, O_STALL);
    end
    tick();
    set_idle();
    tick();
    n_checks++;
    if (bus.ctrl_state !== S_RUN) begin
      n_fail++; $display("FAIL ldu_rt_back_run: got %0d want %0d", bus.ctrl_state, S_RUN);
    end
  endtask

  task automatic test_muldiv_stall();
    set_idle();
    bus.id_md_start = 1'b1; bus.id_md_use = 1'b1;
    #1;
    n_checks++;
    if (outs !== O_ADV) begin
      n_fail++; $display("FAIL md_issue_outs: got %b want %b", outs, O_ADV);
    end
    tick();
    bus.id_md_start = 1'b0;  // mfhi waiting on the result
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (outs !== O_STALL || bus.ctrl_state !== S_MDB) begin
        n_fail++;
        $display("FAIL md_stall_%0d: got outs %b state %0d want outs %b state %0d",
                 i, outs, bus.ctrl_state, O_STALL, S_MDB);
      end
      tick();
    end
    #1;
    n_checks++;
    if (outs !== O_ADV || bus.ctrl_state !== S_MDB) begin
      n_fail++;
      $display("FAIL md_release: got outs %b state %0d want outs %b state %0d",
               outs, bus.ctrl_state, O_ADV, S_MDB);
    end
    tick();
    set_idle();
    n_checks++;
    if (bus.ctrl_state !== S_RUN) begin
      n_fail++; $display("FAIL md_back_run: got %0d want %0d", bus.ctrl_state, S_RUN);
    end
  endtask

  task automatic test_branch_priority();
    set_idle();
    bus.br_taken = 1'b1;
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd9; bus.id_rs = 5'd9;
    bus.id_md_start = 1'b1; bus.id_md_use = 1'b1;  // must not issue
    #1;
    n_checks++;
    if (outs !== O_FLUSH) begin
      n_fail++; $display("FAIL br_ldu_outs: got %b want %b", outs, O_FLUSH);
    end
    tick();
    n_checks++;
    if (bus.ctrl_state !== S_RUN) begin
      n_fail++; $display("FAIL br_ldu_state: got %0d want %0d", bus.ctrl_state, S_RUN);
    end
    set_idle();
  endtask

  task automatic test_back_to_back();
    set_idle();
    bus.id_md_start = 1'b1; bus.id_md_use = 1'b1;
    tick();  // md_cnt = 3
    set_idle();
    #1;
    n_checks++;
    if (outs !== O_ADV || bus.ctrl_state !== S_MDB) begin
      n_fail++;
      $display("FAIL b2b_indep: got outs %b state %0d want outs %b state %0d",
               outs, bus.ctrl_state, O_ADV, S_MDB);
    end
    tick(); tick(); tick();  // md_cnt reaches 0
    bus.id_md_start = 1'b1; bus.id_md_use = 1'b1;
    #1;
    n_checks++;
    if (outs !== O_ADV) begin
      n_fail++; $display("FAIL b2b_reissue_outs: got %b want %b", outs, O_ADV);
    end
    tick();  // reloaded to 3
    n_checks++;
    if (bus.ctrl_state !== S_MDB) begin
      n_fail++; $display("FAIL b2b_reload_state: got %0d want %0d", bus.ctrl_state, S_MDB);
    end
    // branch during busy: flush, counter keeps running (3 -> 2)
    set_idle();
    bus.br_taken = 1'b1; bus.id_md_use = 1'b1;
    #1;
    n_checks++;
    if (outs !== O_FLUSH) begin
      n_fail++; $display("FAIL b2b_br_outs: got %b want %b", outs, O_FLUSH);
    end
    tick();
    // load-use during busy: stall, stay busy (2 -> 1)
    set_idle();
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd4; bus.id_rs = 5'd4;
    #1;
    n_checks++;
    if (outs !== O_STALL) begin
      n_fail++; $display("FAIL b2b_ldu_outs: got %b want %b", outs, O_STALL);
    end
    tick();
    n_checks++;
    if (bus.ctrl_state !== S_MDB) begin
      n_fail++; $display("FAIL b2b_ldu_state: got %0d want %0d", bus.ctrl_state, S_MDB);
    end
    // md stall on the last busy cycle (1 -> 0)
    set_idle();
    bus.id_md_use = 1'b1;
    #1;
    n_checks++;
    if (outs !== O_STALL) begin
      n_fail++; $display("FAIL b2b_last_stall: got %b want %b", outs, O_STALL);
    end
    tick();
    #1;
    n_checks++;
    if (outs !== O_ADV) begin
      n_fail++; $display("FAIL b2b_release: got %b want %b", outs, O_ADV);
    end
    tick();
    set_idle();
    n_checks++;
    if (bus.ctrl_state !== S_RUN) begin
      n_fail++; $display("FAIL b2b_back_run: got %0d want %0d", bus.ctrl_state, S_RUN);
    end
  endtask

  task automatic test_reset_mid_mdbusy();
    set_idle();
    bus.id_md_start = 1'b1; bus.id_md_use = 1'b1;
    tick();
    set_idle();
    tick();
    n_checks++;
    if (bus.ctrl_state !== S_MDB) begin
      n_fail++; $display("FAIL rmid_pre_state: got %0d want %0d", bus.ctrl_state, S_MDB);
    end
    bus.id_md_use = 1'b1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (outs !== O_RST || bus.ctrl_state !== S_RUN) begin
      n_fail++;
      $display("FAIL rmid_in_reset: got outs %b state %0d want outs %b state %0d",
               outs, bus.ctrl_state, O_RST, S_RUN);
    end
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (outs !== O_ADV) begin
      n_fail++; $display("FAIL rmid_after_outs: got %b want %b", outs, O_ADV);
    end
    tick();
    n_checks++;
    if (bus.ctrl_state !== S_RUN) begin
      n_fail++; $display("FAIL rmid_after_state: got %0d want %0d", bus.ctrl_state, S_RUN);
    end
    set_idle();
  endtask

`ifdef HAZ_PERF_CNT_EN
  task automatic test_perf_counters();
    set_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (stall_cnt !== 4'h0 || flush_cnt !== 4'h0) begin
      n_fail++;
      $display("FAIL perf_reset: got stall %h flush %h want 0 0", stall_cnt, flush_cnt);
    end
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd7; bus.id_rs = 5'd7;
    repeat (20) tick();
    set_idle();
    #1;
    n_checks++;
    if (stall_cnt !== 4'hF) begin
      n_fail++; $display("FAIL perf_stall_sat: got %h want %h", stall_cnt, 4'hF);
    end
    bus.br_taken = 1'b1;
    repeat (3) tick();
    set_idle();
    #1;
    n_checks++;
    if (flush_cnt !== 4'h3) begin
      n_fail++; $display("FAIL perf_flush: got %h want %h", flush_cnt, 4'h3);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    set_idle();
    test_reset();
    test_load_use();
    test_muldiv_stall();
    test_branch_priority();
    test_back_to_back();
    test_reset_mid_mdbusy();
`ifdef HAZ_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
